// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan decoder: segment patterns
// ({a,b,c,d,e,f,g}, a = MSB) and the capture FSM state type.
package ssd_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

endpackage

// File: rtl/ssd_encode_hex.sv
// Combinational segment-pattern classifier: hex digit, blank, or invalid.
module ssd_encode_hex
    import ssd_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_is_hex,
    output logic       o_is_blank
);

    always_comb begin
        o_nibble   = 4'h0;
        o_is_hex   = 1'b1;
        o_is_blank = 1'b0;
        case (i_seg)
            SEG_0:     o_nibble = 4'h0;
            SEG_1:     o_nibble = 4'h1;
            SEG_2:     o_nibble = 4'h2;
            SEG_3:     o_nibble = 4'h3;
            SEG_4:     o_nibble = 4'h4;
            SEG_5:     o_nibble = 4'h5;
            SEG_6:     o_nibble = 4'h6;
            SEG_7:     o_nibble = 4'h7;
            SEG_8:     o_nibble = 4'h8;
            SEG_9:     o_nibble = 4'h9;
            SEG_A:     o_nibble = 4'hA;
            SEG_B:     o_nibble = 4'hB;
            SEG_C:     o_nibble = 4'hC;
            SEG_D:     o_nibble = 4'hD;
            SEG_E:     o_nibble = 4'hE;
            SEG_F:     o_nibble = 4'hF;
            SEG_BLANK: begin
                o_is_hex   = 1'b0;
                o_is_blank = 1'b1;
            end
            default:   o_is_hex = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_scan_decode.sv
// Multiplexed seven-segment display snooper: waits for a stable one-hot digit
// strobe, captures the decoded nibble per digit and posts a capture event.
// Optional SSD_SCAN_SYNC_EN adds a 2-flop input synchroniser for async sources.
module ssd_scan_decode
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] values,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   invalid,
    output logic                    upd_valid,
    input  logic                    upd_ready,
    output logic [2:0]              upd_idx,
    output logic [3:0]              upd_value,
    output logic                    overrun
);

    logic [1:0]              r_rst_sync;
    logic                    w_rst_n;
    logic [6:0]              w_seg_src, r_seg, r_seg_prev;
    logic [NUM_DIGITS-1:0]   w_dig_src, r_dig, r_dig_prev;
    state_t                  r_state;
    logic [7:0]              r_cnt, w_cnt_inc;
    logic                    w_onehot, w_same, w_capture;
    logic [2:0]              w_idx;
    logic [3:0]              w_nibble;
    logic                    w_is_hex, w_is_blank;
    logic [4*NUM_DIGITS-1:0] r_values;
    logic [NUM_DIGITS-1:0]   r_digit_valid, r_invalid;
    logic                    r_upd_valid, r_overrun;
    logic [2:0]              r_upd_idx;
    logic [3:0]              r_upd_value;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= '0;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

`ifdef SSD_SCAN_SYNC_EN
    logic [1:0][6:0]            r_seg_sync;
    logic [1:0][NUM_DIGITS-1:0] r_dig_sync;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_seg_sync <= '0;
            r_dig_sync <= '0;
        end else begin
            r_seg_sync <= {r_seg_sync[0], seg_in};
            r_dig_sync <= {r_dig_sync[0], dig_en};
        end
    end
    assign w_seg_src = r_seg_sync[1];
    assign w_dig_src = r_dig_sync[1];
`else
    assign w_seg_src = seg_in;
    assign w_dig_src = dig_en;
`endif

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_seg      <= '0;
            r_dig      <= '0;
            r_seg_prev <= '0;
            r_dig_prev <= '0;
        end else begin
            r_seg      <= w_seg_src;
            r_dig      <= w_dig_src;
            r_seg_prev <= r_seg;
            r_dig_prev <= r_dig;
        end
    end

    ssd_encode_hex u_enc (
        .i_seg      (r_seg),
        .o_nibble   (w_nibble),
        .o_is_hex   (w_is_hex),
        .o_is_blank (w_is_blank)
    );

    assign w_onehot  = $onehot(r_dig);
    assign w_same    = (r_seg == r_seg_prev) && (r_dig == r_dig_prev);
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_capture = (r_state == SETTLE) && w_same && (w_cnt_inc == 8'(STABLE_CYCLES - 1));

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (r_dig[i]) w_idx = 3'(i);
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_values      <= '0;
            r_digit_valid <= '0;
            r_invalid     <= '0;
            r_upd_valid   <= 1'b0;
            r_upd_idx     <= '0;
            r_upd_value   <= '0;
            r_overrun     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_onehot) begin
                    r_state <= SETTLE;
                    r_cnt   <= '0;
                end
                SETTLE: begin
                    if (!w_same) begin
                        r_cnt <= '0;
                        if (!w_onehot) r_state <= IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_capture) r_state <= HELD;
                    end
                end
                HELD: if (!w_same) begin
                    r_cnt   <= '0;
                    r_state <= w_onehot ? SETTLE : IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_capture) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (r_dig[i]) begin
                        if (w_is_hex) r_values[4*i +: 4] <= w_nibble;
                        r_digit_valid[i] <= w_is_hex;
                        r_invalid[i]     <= !w_is_hex && !w_is_blank;
                    end
                end
                // A same-cycle acceptance frees the slot, so the new event replaces it.
                if (!r_upd_valid || upd_ready) begin
                    r_upd_valid <= 1'b1;
                    r_upd_idx   <= w_idx;
                    r_upd_value <= w_is_hex ? w_nibble : 4'h0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_upd_valid && upd_ready) begin
                r_upd_valid <= 1'b0;
            end
        end
    end

    assign values      = r_values;
    assign digit_valid = r_digit_valid;
    assign invalid     = r_invalid;
    assign upd_valid   = r_upd_valid;
    assign upd_idx     = r_upd_idx;
    assign upd_value   = r_upd_value;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_ssd_scan_decode.sv
// Directed self-checking bench for ssd_scan_decode (default parameters).
module tb_ssd_scan_decode;

`ifdef SSD_SCAN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_en = '0;
    logic [15:0] values;
    logic [3:0]  digit_valid, invalid;
    logic        upd_valid, upd_ready = 1'b1;
    logic [2:0]  upd_idx;
    logic [3:0]  upd_value;
    logic        overrun;

    int n_chk = 0, n_pass = 0;
    int ev_cnt = 0;
    logic [2:0] ev_idx = '0;
    logic [3:0] ev_val = '0;

    ssd_scan_decode dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_en(dig_en),
        .values(values), .digit_valid(digit_valid), .invalid(invalid),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx),
        .upd_value(upd_value), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Log every accepted event, sampled mid-cycle before the accepting edge.
    always begin
        @(negedge clk);
        #2;
        if (upd_valid && upd_ready) begin
            ev_cnt = ev_cnt + 1;
            ev_idx = upd_idx;
            ev_val = upd_value;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] seg, input logic [3:0] dig);
        @(negedge clk);
        #1;
        seg_in = seg;
        dig_en = dig;
    endtask

    task automatic set_rdy(input logic r);
        @(negedge clk);
        #1;
        upd_ready = r;
    endtask

    initial begin
        #3;
        chk("rst_values", 32'(values), 32'h0);
        chk("rst_dv", 32'(digit_valid), 32'h0);
        chk("rst_inv", 32'(invalid), 32'h0);
        chk("rst_upd_valid", 32'(upd_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4);

        // 5B on digit 0: captured after the 8th sample.
        drive(7'h5B, 4'b0001);
        cyc(8 + LAT);
        chk("t1_early_dv", 32'(digit_valid), 32'h0);
        chk("t1_early_ev", 32'(upd_valid), 32'h0);
        cyc(1);
        chk("t1_values", 32'(values), 32'h0005);
        chk("t1_dv", 32'(digit_valid), 32'h1);
        chk("t1_upd_valid", 32'(upd_valid), 32'h1);
        chk("t1_upd_idx", 32'(upd_idx), 32'h0);
        chk("t1_upd_value", 32'(upd_value), 32'h5);
        cyc(4);
        chk("t1_ev_cnt", 32'(ev_cnt), 32'd1);
        chk("t1_ev_cleared", 32'(upd_valid), 32'h0);

        // 5B for 4 samples then 5F: window restarts on the change.
        drive(7'h00, 4'b0000);
        cyc(3);
        drive(7'h5B, 4'b0001);
        cyc(4);
        drive(7'h5F, 4'b0001);
        cyc(8 + LAT);
        chk("t2_no_early_ev", 32'(ev_cnt), 32'd1);
        chk("t2_no_early_upd", 32'(upd_valid), 32'h0);
        chk("t2_values_held", 32'(values), 32'h0005);
        cyc(1);
        chk("t2_values", 32'(values), 32'h0006);
        chk("t2_upd_value", 32'(upd_value), 32'h6);
        cyc(2);
        chk("t2_ev_cnt", 32'(ev_cnt), 32'd2);
        chk("t2_ev_val", 32'(ev_val), 32'h6);

        // Digit 2: hex 4, then invalid 01, then blank.
        drive(7'h33, 4'b0100);
        cyc(9 + LAT);
        chk("t3_hex_values", 32'(values), 32'h0406);
        chk("t3_hex_dv", 32'(digit_valid), 32'h5);
        cyc(2);
        drive(7'h01, 4'b0100);
        cyc(9 + LAT);
        chk("t3_inv", 32'(invalid), 32'h4);
        chk("t3_inv_dv", 32'(digit_valid), 32'h1);
        chk("t3_inv_values", 32'(values), 32'h0406);
        chk("t3_inv_upd_valid", 32'(upd_valid), 32'h1);
        chk("t3_inv_upd_idx", 32'(upd_idx), 32'h2);
        chk("t3_inv_upd_value", 32'(upd_value), 32'h0);
        cyc(2);
        drive(7'h00, 4'b0100);
        cyc(9 + LAT);
        chk("t3_blank_inv", 32'(invalid), 32'h0);
        chk("t3_blank_dv", 32'(digit_valid), 32'h1);
        chk("t3_blank_values", 32'(values), 32'h0406);
        chk("t3_blank_upd_idx", 32'(upd_idx), 32'h2);
        cyc(2);
        chk("t3_ev_cnt", 32'(ev_cnt), 32'd5);

        // Two strobes at once: nothing captured.
        drive(7'h7E, 4'b0011);
        cyc(20);
        chk("t4_values", 32'(values), 32'h0406);
        chk("t4_dv", 32'(digit_valid), 32'h1);
        chk("t4_inv", 32'(invalid), 32'h0);
        chk("t4_ev_cnt", 32'(ev_cnt), 32'd5);
        chk("t4_upd_valid", 32'(upd_valid), 32'h0);

        // Back-pressure: second capture dropped, overrun set, registers still update.
        set_rdy(1'b0);
        drive(7'h00, 4'b0000);
        cyc(3);
        drive(7'h30, 4'b0001);
        cyc(9 + LAT);
        chk("t5_first_valid", 32'(upd_valid), 32'h1);
        chk("t5_first_value", 32'(upd_value), 32'h1);
        chk("t5_no_overrun", 32'(overrun), 32'h0);
        drive(7'h6D, 4'b0010);
        cyc(9 + LAT);
        chk("t5_overrun", 32'(overrun), 32'h1);
        chk("t5_held_idx", 32'(upd_idx), 32'h0);
        chk("t5_held_value", 32'(upd_value), 32'h1);
        chk("t5_values", 32'(values), 32'h0421);
        chk("t5_dv", 32'(digit_valid), 32'h3);
        set_rdy(1'b1);
        cyc(2);
        chk("t5_ev_cnt", 32'(ev_cnt), 32'd6);
        chk("t5_ev_val", 32'(ev_val), 32'h1);
        chk("t5_cleared", 32'(upd_valid), 32'h0);
        chk("t5_overrun_sticky", 32'(overrun), 32'h1);

        // Reset four samples into a window.
        drive(7'h4E, 4'b1000);
        cyc(4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_values", 32'(values), 32'h0);
        chk("t6_dv", 32'(digit_valid), 32'h0);
        chk("t6_inv", 32'(invalid), 32'h0);
        chk("t6_upd_valid", 32'(upd_valid), 32'h0);
        chk("t6_overrun", 32'(overrun), 32'h0);
        chk("t6_upd_idx", 32'(upd_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(8);
        chk("t6_no_early", 32'(digit_valid), 32'h0);
        for (int i = 0; i < 20 && digit_valid !== 4'b1000; i++) cyc(1);
        chk("t6_dv", 32'(digit_valid), 32'h8);
        chk("t6_values_cap", 32'(values), 32'hC000);
        chk("t6_upd_idx_cap", 32'(upd_idx), 32'h3);
        chk("t6_upd_value_cap", 32'(upd_value), 32'hC);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
